// File: rtl/resource_arbiter_pkg.sv
// Shared defines, FSM encoding and helpers for resource_arbiter.
// Widths default here when no project-wide definition has been seen first.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef ARB_ST_W
`define ARB_ST_W 2
`define ARB_IDLE 2'd0
`define ARB_ISSUE 2'd1
`define ARB_HOLD 2'd2
`endif

package resource_arbiter_pkg;

  typedef enum logic [`ARB_ST_W-1:0] {
    ST_IDLE  = `ARB_IDLE,
    ST_ISSUE = `ARB_ISSUE,
    ST_HOLD  = `ARB_HOLD
  } arb_state_e;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/resource_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search, first set request at or after ptr
// (modulo NUM_REQ).
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  always_comb begin
    int j;
    j          = 0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[j]) begin
        any           = 1'b1;
        gnt_idx       = IDX_W'(j);
        gnt_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/resource_arbiter.sv
// resource_arbiter: shares one pipelined resource between NUM_REQ requesters
// through a one-entry output register. RESOURCE_ARB_FIXED_SLOT_EN selects TDM slots.
module resource_arbiter
  import resource_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*`DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           res_valid,
  output logic [`DATA_WIDTH-1:0]         res_data,
  output logic [`ID_WIDTH-1:0]           res_id,
  input  logic                           res_stall,
  output logic [`ARB_ST_W-1:0]           dbg_state
);

  // Handshake: beat i transfers on a rising edge where req_valid[i] & req_ready[i];
  // res_* transfers where res_valid & !res_stall. Ready never depends on ready.
  arb_state_e         state;
  logic               free;
  logic               accept;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;

  assign free = !res_valid || !res_stall;

`ifdef RESOURCE_ARB_FIXED_SLOT_EN
  // Slot advances whenever the register is free, so a requester's timing never
  // depends on whether other requesters used their slots.
  logic [IDX_W-1:0] slot;

  always_comb begin
    pick_onehot       = '0;
    pick_onehot[slot] = req_valid[slot];
    pick_idx          = slot;
  end

  assign accept = free && req_valid[slot];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot <= '0;
    end else if (free) begin
      slot <= IDX_W'(wrap_inc(int'(slot), NUM_REQ));
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;
  logic             pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req        (req_valid),
    .ptr        (rr_ptr),
    .gnt_onehot (pick_onehot),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  assign accept = free && pick_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= IDX_W'(wrap_inc(int'(pick_idx), NUM_REQ));
    end
  end
`endif

  assign req_ready = (free && !reset) ? pick_onehot : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      state     <= ST_IDLE;
    end else if (free) begin
      if (accept) begin
        res_valid <= 1'b1;
        res_data  <= req_data[int'(pick_idx)*`DATA_WIDTH +: `DATA_WIDTH];
        res_id    <= `ID_WIDTH'(pick_idx);
        state     <= ST_ISSUE;
      end else begin
        res_valid <= 1'b0;
        state     <= ST_IDLE;
      end
    end else begin
      state <= ST_HOLD;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_resource_arbiter.sv
// Self-checking bench for resource_arbiter: vector table plus hand-written
// stall/reset sequences; fixed-slot scenarios when RESOURCE_ARB_FIXED_SLOT_EN is set.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
module tb_resource_arbiter;
  import resource_arbiter_pkg::*;

`ifdef RESOURCE_ARB_FIXED_SLOT_EN
  localparam int N = 3;
`else
  localparam int N = 4;
`endif
  localparam int DW = `DATA_WIDTH;
  localparam int IW = `ID_WIDTH;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N-1:0]         req_valid;
  logic [N*DW-1:0]      req_data;
  logic [N-1:0]         req_ready;
  logic                 res_valid;
  logic [DW-1:0]        res_data;
  logic [IW-1:0]        res_id;
  logic                 res_stall;
  logic [`ARB_ST_W-1:0] dbg_state;

  resource_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_stall (res_stall),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  logic [IW+DW-1:0] exp_q[$];
  logic [IW+DW-1:0] cur;
  logic [DW-1:0]    d [N];
  logic             prev_rv;
  logic [N-1:0]     rdy_seen;
  int               checks;
  int               errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, check ready before the edge, check res_* after it.
  task automatic run_cycle(input logic [N-1:0] v, input logic st, input logic [N-1:0] exp_rdy,
                           input int exp_id, input string name);
    logic held;
    logic exp_rv;
    for (int i = 0; i < N; i++) if (!v[i]) d[i] = DW'($urandom_range(0, 255));
    req_valid = v;
    res_stall = st;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = d[i];
    #1;
    rdy_seen = req_ready;
    chk({name, " ready"}, 32'(req_ready), 32'(exp_rdy));
    held = prev_rv && st;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) exp_q.push_back({IW'(i), d[i]});
    exp_rv = held || (exp_rdy != '0);
    @(posedge clk);
    #1;
    chk({name, " res_valid"}, 32'(res_valid), 32'(exp_rv));
    if (exp_rv) begin
      if (!held && exp_q.size() > 0) cur = exp_q.pop_front();
      chk({name, " res_id"}, 32'(res_id), 32'(cur[IW+DW-1:DW]));
      chk({name, " res_id_tbl"}, 32'(res_id), exp_id);
      chk({name, " res_data"}, 32'(res_data), 32'(cur[DW-1:0]));
    end
    chk({name, " state"}, 32'(dbg_state),
        held ? 32'(ST_HOLD) : (exp_rv ? 32'(ST_ISSUE) : 32'(ST_IDLE)));
    prev_rv = exp_rv;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    res_stall = 1'b0;
    req_valid = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset ready", 32'(req_ready), 0);
    chk("reset res_valid", 32'(res_valid), 0);
    chk("reset res_data", 32'(res_data), 0);
    chk("reset res_id", 32'(res_id), 0);
    chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
    req_valid = '0;
    reset     = 1'b0;
    prev_rv   = 1'b0;
    exp_q.delete();
  endtask

`ifndef RESOURCE_ARB_FIXED_SLOT_EN
  typedef struct {
    logic [N-1:0] v;
    logic         st;
    logic [N-1:0] rdy;
    int           id;
  } vec_t;
  vec_t tbl [10];
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    prev_rv   = 1'b0;
    cur       = '0;
    rdy_seen  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) d[i] = DW'($urandom_range(0, 255));
`ifdef RESOURCE_ARB_FIXED_SLOT_EN
    begin
      logic [N-1:0] pend;
      logic [N-1:0] v;
      logic [N-1:0] e;
      logic [11:0]  mask;
      for (int pass = 0; pass < 2; pass++) begin
        do_reset();
        pend = '0;
        mask = '0;
        for (int c = 0; c < 12; c++) begin
          for (int i = 0; i < 2; i++)
            if (pass == 1 && !pend[i]) pend[i] = 1'($urandom_range(0, 1));
          v    = {1'b1, pend[1:0]};
          e    = '0;
          e[c % 3] = v[c % 3];
          run_cycle(v, 1'b0, e, c % 3, pass == 0 ? "slot_alone" : "slot_mixed");
          mask[c] = rdy_seen[2];
          for (int i = 0; i < 2; i++) if (e[i]) pend[i] = 1'b0;
        end
        chk(pass == 0 ? "slot2_cycles_alone" : "slot2_cycles_mixed", 32'(mask), 32'h924);
      end
    end
`else
    d[2] = 8'hA5;
    // Rotation from reset, then a single requester, then idle.
    tbl[0] = '{v: 4'b1111, st: 1'b0, rdy: 4'b0001, id: 0};
    tbl[1] = '{v: 4'b1111, st: 1'b0, rdy: 4'b0010, id: 1};
    tbl[2] = '{v: 4'b1111, st: 1'b0, rdy: 4'b0100, id: 2};
    tbl[3] = '{v: 4'b1111, st: 1'b0, rdy: 4'b1000, id: 3};
    tbl[4] = '{v: 4'b1111, st: 1'b0, rdy: 4'b0001, id: 0};
    tbl[5] = '{v: 4'b1111, st: 1'b0, rdy: 4'b0010, id: 1};
    tbl[6] = '{v: 4'b0100, st: 1'b0, rdy: 4'b0100, id: 2};
    tbl[7] = '{v: 4'b0100, st: 1'b0, rdy: 4'b0100, id: 2};
    tbl[8] = '{v: 4'b0100, st: 1'b0, rdy: 4'b0100, id: 2};
    tbl[9] = '{v: 4'b0000, st: 1'b0, rdy: 4'b0000, id: 2};
    do_reset();
    for (int r = 0; r < 10; r++) run_cycle(tbl[r].v, tbl[r].st, tbl[r].rdy, tbl[r].id, "table");
    chk("single_data_a5", 32'(cur[DW-1:0]), 32'h0A5);

    // Stall holds the beat bit-exact and freezes the pointer.
    d[1] = 8'h3C;
    run_cycle(4'b0010, 1'b0, 4'b0010, 1, "stall_load");
    for (int k = 0; k < 5; k++) run_cycle(4'b1111, 1'b1, 4'b0000, 1, "stall_hold");
    chk("stall_data_3c", 32'(res_data), 32'h03C);
    run_cycle(4'b1111, 1'b0, 4'b0100, 2, "stall_release");
    run_cycle(4'b1111, 1'b1, 4'b0000, 2, "hold_again");

    // Asynchronous reset while in HOLD.
    reset = 1'b1;
    #1;
    chk("async_reset res_valid", 32'(res_valid), 0);
    chk("async_reset ready", 32'(req_ready), 0);
    chk("async_reset state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    prev_rv = 1'b0;
    exp_q.delete();
    run_cycle(4'b1111, 1'b0, 4'b0001, 0, "post_reset_first");
    run_cycle(4'b1111, 1'b0, 4'b0010, 1, "post_reset_second");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
